// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the t1c multi-cycle controller: opcodes, FSM states,
// branch funct3 codes and datapath mux selects.
package riscv_ctrl_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR     = 4'd11,
      S_UPPER    = 4'd12,
      S_TRAP     = 4'd13
   } state_t;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_READ   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   // Immediate format DECODE needs so ALUOut holds OldPC+imm for branch/jal.
   function automatic logic [2:0] imm_for_op(input logic [6:0] op);
      case (op)
         OP_STORE:         return IMM_S;
         OP_BRANCH:        return IMM_B;
         OP_JAL:           return IMM_J;
         OP_LUI, OP_AUIPC: return IMM_U;
         default:          return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/branch_unit.sv
// Resolves RV32I branch conditions from ALU flags of rs1-rs2 and flags
// funct3 codes this build does not support.
module branch_unit
   import riscv_ctrl_pkg::*;
#(
   parameter int FULL_BRANCH = 1
) (
   input  logic [2:0] funct3,
   input  logic       Zero,
   input  logic       Neg,
   input  logic       Ovf,
   input  logic       Carry,
   output logic       taken,
   output logic       illegal
);

   always_comb begin
      taken   = 1'b0;
      illegal = 1'b0;
      case (funct3)
         F3_BEQ:  taken = Zero;
         F3_BNE:  taken = !Zero;
         F3_BLT:  taken = Neg ^ Ovf;
         F3_BGE:  taken = !(Neg ^ Ovf);
         F3_BLTU: taken = !Carry;
         F3_BGEU: taken = Carry;
         default: illegal = 1'b1;
      endcase
      // Reduced build keeps only beq/bne; the signed/unsigned compares trap.
      if (FULL_BRANCH == 0 && funct3[2]) illegal = 1'b1;
      if (illegal) taken = 1'b0;
   end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-style multi-cycle main controller for the t1c core; sequences
// fetch/decode/execute/memory/write-back and traps on illegal ops or timeouts.
module multicycle_controller
   import riscv_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int FULL_BRANCH = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       Zero,
   input  logic       Neg,
   input  logic       Ovf,
   input  logic       Carry,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       MemWrite,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] ResultSrc,
   output logic [2:0] ImmSrc,
   output logic       fault
);

   localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

   state_t          state_q, state_d;
   logic [CW-1:0]   wait_q, wait_d;
   logic            req_c, memwrite_c, irwrite_c, pcwrite_c, regwrite_c;
   logic            br_taken, br_illegal, timeout;

   branch_unit #(.FULL_BRANCH(FULL_BRANCH)) u_branch (
      .funct3  (funct3),
      .Zero    (Zero),
      .Neg     (Neg),
      .Ovf     (Ovf),
      .Carry   (Carry),
      .taken   (br_taken),
      .illegal (br_illegal)
   );

   assign timeout = (MEM_TIMEOUT != 0) && req_c && !mem_ready
                    && (wait_q == CW'(MEM_TIMEOUT));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      req_c      = 1'b0;
      memwrite_c = 1'b0;
      irwrite_c  = 1'b0;
      pcwrite_c  = 1'b0;
      regwrite_c = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_RS2;
      ALUOp      = ALUOP_ADD;
      ResultSrc  = RES_ALUOUT;
      ImmSrc     = IMM_I;
      case (state_q)
         S_FETCH: begin
            req_c     = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALU;
            irwrite_c = mem_ready;
            pcwrite_c = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = imm_for_op(op);
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECR;
               OP_ITYPE:          state_d = S_EXECI;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALR;
               OP_LUI, OP_AUIPC:  state_d = S_UPPER;
               default:           state_d = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
            state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            req_c  = 1'b1;
            AdrSrc = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc  = RES_READ;
            regwrite_c = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWRITE: begin
            req_c      = 1'b1;
            memwrite_c = 1'b1;
            AdrSrc     = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXECR: begin
            ALUSrcA = SRCA_RS1;
            ALUOp   = ALUOP_FUNC;
            state_d = S_ALUWB;
         end
         S_EXECI: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_FUNC;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            regwrite_c = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA   = SRCA_RS1;
            ALUOp     = ALUOP_SUB;
            pcwrite_c = br_taken;
            state_d   = br_illegal ? S_TRAP : S_FETCH;
         end
         S_JAL: begin
            // PC takes the target in ALUOut while the ALU forms the link value.
            ALUSrcA   = SRCA_OLDPC;
            ALUSrcB   = SRCB_FOUR;
            pcwrite_c = 1'b1;
            state_d   = S_ALUWB;
         end
         S_JALR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            state_d = S_JAL;
         end
         S_UPPER: begin
            ALUSrcA = (op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = IMM_U;
            state_d = S_ALUWB;
         end
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_TRAP;
      endcase
      if (timeout) state_d = S_TRAP;
   end

   // Counter restarts for every new access because any state change clears it.
   always_comb begin
      wait_d = wait_q;
      if (mem_ready || state_d != state_q) wait_d = '0;
      else if (req_c)                      wait_d = wait_q + CW'(1);
   end

   assign mem_req  = req_c      && !reset;
   assign MemWrite = memwrite_c && !reset;
   assign IRWrite  = irwrite_c  && !reset;
   assign PCWrite  = pcwrite_c  && !reset;
   assign RegWrite = regwrite_c && !reset;
   assign fault    = (state_q == S_TRAP);

endmodule

// File: tb/tb_multicycle_controller.sv
// Trace-model bench: each instruction is expanded into an expected per-cycle
// output trace from the instruction-level rules, then replayed and compared.
module tb_multicycle_controller;

   localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                          IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111,
                          JR = 7'b1100111, LU = 7'b0110111, AU = 7'b0010111;
   localparam logic [17:0] RMASK = 18'h37000;

   typedef struct {
      bit          sel;
      bit          rst;
      bit          rdy;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [3:0]  fl;
      logic [17:0] exp;
      logic [17:0] mask;
      bit          lit_en;
      logic [17:0] lit;
      string       nm;
   } cyc_t;

   logic clk = 1'b0;
   logic rst1 = 1'b1, rst2 = 1'b1;
   logic [6:0] op = '0;
   logic [2:0] funct3 = '0;
   logic Zero = 1'b0, Neg = 1'b0, Ovf = 1'b0, Carry = 1'b0, mem_ready = 1'b0;

   logic mr1, mw1, ad1, ir1, pc1, rw1, ft1, mr2, mw2, ad2, ir2, pc2, rw2, ft2;
   logic [1:0] sa1, sb1, ao1, rs1, sa2, sb2, ao2, rs2;
   logic [2:0] im1, im2;
   logic [17:0] o1, o2;

   always #5 clk = ~clk;

   multicycle_controller #(.MEM_TIMEOUT(15), .FULL_BRANCH(1)) dut (
      .clk(clk), .reset(rst1), .op(op), .funct3(funct3), .Zero(Zero), .Neg(Neg),
      .Ovf(Ovf), .Carry(Carry), .mem_ready(mem_ready), .mem_req(mr1), .MemWrite(mw1),
      .AdrSrc(ad1), .IRWrite(ir1), .PCWrite(pc1), .RegWrite(rw1), .ALUSrcA(sa1),
      .ALUSrcB(sb1), .ALUOp(ao1), .ResultSrc(rs1), .ImmSrc(im1), .fault(ft1));

   multicycle_controller #(.MEM_TIMEOUT(4), .FULL_BRANCH(0)) dut2 (
      .clk(clk), .reset(rst2), .op(op), .funct3(funct3), .Zero(Zero), .Neg(Neg),
      .Ovf(Ovf), .Carry(Carry), .mem_ready(mem_ready), .mem_req(mr2), .MemWrite(mw2),
      .AdrSrc(ad2), .IRWrite(ir2), .PCWrite(pc2), .RegWrite(rw2), .ALUSrcA(sa2),
      .ALUSrcB(sb2), .ALUOp(ao2), .ResultSrc(rs2), .ImmSrc(im2), .fault(ft2));

   assign o1 = {mr1, mw1, ad1, ir1, pc1, rw1, sa1, sb1, ao1, rs1, im1, ft1};
   assign o2 = {mr2, mw2, ad2, ir2, pc2, rw2, sa2, sb2, ao2, rs2, im2, ft2};

   cyc_t q[$];
   cyc_t cur;
   bit   chk_en = 1'b0;
   int   n_chk = 0, n_pass = 0;

   // model build state
   bit         m_sel, mtrap;
   int         mt;
   bit         fb;
   logic [6:0] c_op;
   logic [2:0] c_f3;
   logic [3:0] c_fl;

   function automatic logic [17:0] ov(input bit mr, mw, adr, ir, pcw, rw,
                                      input logic [1:0] a, b, aop, res,
                                      input logic [2:0] imm, input bit flt);
      return {mr, mw, adr, ir, pcw, rw, a, b, aop, res, imm, flt};
   endfunction

   task automatic push(input bit rst, input bit rdy, input logic [17:0] exp,
                       input logic [17:0] mask, input string nm);
      cyc_t t;
      t.sel = m_sel; t.rst = rst; t.rdy = rdy; t.op = c_op; t.f3 = c_f3; t.fl = c_fl;
      t.exp = exp; t.mask = mask; t.lit_en = 1'b0; t.lit = '0; t.nm = nm;
      q.push_back(t);
   endtask

   task automatic pin(input logic [17:0] v);
      cyc_t t;
      t = q[q.size()-1];
      t.lit_en = 1'b1; t.lit = v;
      q[q.size()-1] = t;
   endtask

   task automatic m_reset();
      push(1'b1, 1'b0, 18'h0, RMASK, "reset");
      mtrap = 1'b0;
   endtask

   task automatic m_trap(input int n);
      repeat (n) push(1'b0, 1'b0, ov(0,0,0,0,0,0,0,0,0,0,0,1), '1, "trap");
   endtask

   // A memory access of `waits` not-ready cycles; gives up at the timeout.
   task automatic m_access(input int waits, input logic [17:0] busy,
                           input logic [17:0] done, input string nm, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < waits; i++) begin
         push(1'b0, 1'b0, busy, '1, nm);
         if (mt != 0 && i == mt) begin
            mtrap = 1'b1;
            return;
         end
      end
      push(1'b0, 1'b1, done, '1, nm);
      ok = 1'b1;
   endtask

   task automatic instr(input logic [6:0] o, input logic [2:0] f, input int fw,
                        input int mw, input logic [31:0] a = 0, input logic [31:0] b = 0);
      bit ok, tk, il;
      logic [2:0] imm;
      logic [31:0] d;
      if (mtrap) return;
      d = a - b;
      c_op = o; c_f3 = f;
      c_fl = {d == 0, d[31], (a[31] != b[31]) && (d[31] != a[31]), a >= b};
      m_access(fw, ov(1,0,0,0,0,0,0,2,0,2,0,0), ov(1,0,0,1,1,0,0,2,0,2,0,0), "fetch", ok);
      if (!ok) return;
      imm = (o == SW) ? 3'd1 : (o == BR) ? 3'd2 : (o == JL) ? 3'd3 :
            (o == LU || o == AU) ? 3'd4 : 3'd0;
      push(1'b0, 1'b0, ov(0,0,0,0,0,0,1,1,0,0,imm,0), '1, "decode");
      case (o)
         LW: begin
            push(1'b0, 1'b0, ov(0,0,0,0,0,0,2,1,0,0,0,0), '1, "memadr");
            m_access(mw, ov(1,0,1,0,0,0,0,0,0,0,0,0), ov(1,0,1,0,0,0,0,0,0,0,0,0), "memread", ok);
            if (ok) push(1'b0, 1'b0, ov(0,0,0,0,0,1,0,0,0,1,0,0), '1, "memwb");
         end
         SW: begin
            push(1'b0, 1'b0, ov(0,0,0,0,0,0,2,1,0,0,1,0), '1, "memadr");
            m_access(mw, ov(1,1,1,0,0,0,0,0,0,0,0,0), ov(1,1,1,0,0,0,0,0,0,0,0,0), "memwrite", ok);
         end
         RT, IT: begin
            push(1'b0, 1'b0, ov(0,0,0,0,0,0,2,(o == IT) ? 2'd1 : 2'd0,2,0,0,0), '1, "exec");
            push(1'b0, 1'b0, ov(0,0,0,0,0,1,0,0,0,0,0,0), '1, "aluwb");
         end
         BR: begin
            il = (f == 3'd2) || (f == 3'd3) || (!fb && f[2]);
            case (f)
               3'd0:    tk = (a == b);
               3'd1:    tk = (a != b);
               3'd4:    tk = ($signed(a) < $signed(b));
               3'd5:    tk = ($signed(a) >= $signed(b));
               3'd6:    tk = (a < b);
               default: tk = (a >= b);
            endcase
            push(1'b0, 1'b0, ov(0,0,0,0,tk && !il,0,2,0,1,0,0,0), '1, "branch");
            if (il) mtrap = 1'b1;
         end
         JL, JR: begin
            if (o == JR) push(1'b0, 1'b0, ov(0,0,0,0,0,0,2,1,0,0,0,0), '1, "jalr");
            push(1'b0, 1'b0, ov(0,0,0,0,1,0,1,2,0,0,0,0), '1, "jal");
            push(1'b0, 1'b0, ov(0,0,0,0,0,1,0,0,0,0,0,0), '1, "aluwb");
         end
         LU, AU: begin
            push(1'b0, 1'b0, ov(0,0,0,0,0,0,(o == LU) ? 2'd3 : 2'd1,1,0,0,4,0), '1, "upper");
            push(1'b0, 1'b0, ov(0,0,0,0,0,1,0,0,0,0,0,0), '1, "aluwb");
         end
         default: mtrap = 1'b1;
      endcase
   endtask

   task automatic chk_int(input string nm, input int got, input int want);
      n_chk++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got %0d want %0d", nm, got, want);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         logic [17:0] act;
         act = cur.sel ? o2 : o1;
         n_chk++;
         if ((act & cur.mask) === (cur.exp & cur.mask)) n_pass++;
         else $display("FAIL %s t=%0t: got %h want %h (mask %h)", cur.nm, $time, act, cur.exp, cur.mask);
         if (cur.lit_en) begin
            n_chk++;
            if (act === cur.lit) n_pass++;
            else $display("FAIL %s literal t=%0t: got %h want %h", cur.nm, $time, act, cur.lit);
         end
      end
   end

   initial begin
      int n0;
      m_sel = 1'b0; mt = 15; fb = 1'b1; mtrap = 1'b0;
      c_op = '0; c_f3 = '0; c_fl = '0;
      m_reset(); m_reset();
      n0 = q.size(); instr(RT, 3'd0, 0, 0); chk_int("add_cycles", q.size() - n0, 4);
      pin(18'h01000);
      n0 = q.size(); instr(LW, 3'd2, 0, 3); chk_int("lw_wait3_cycles", q.size() - n0, 8);
      pin(18'h01010);
      instr(SW, 3'd2, 1, 0);
      instr(IT, 3'd0, 2, 0);
      instr(JL, 3'd0, 0, 0);
      n0 = q.size(); instr(JR, 3'd0, 0, 0); chk_int("jalr_cycles", q.size() - n0, 5);
      instr(LU, 3'd0, 0, 0);
      instr(AU, 3'd0, 0, 0);
      n0 = q.size(); instr(BR, 3'd0, 0, 0, 32'd7, 32'd7); chk_int("beq_cycles", q.size() - n0, 3);
      instr(BR, 3'd1, 0, 0, 32'd7, 32'd7);
      instr(BR, 3'd4, 0, 0, 32'hFFFF_FFFF, 32'd1);
      pin(18'h02840);
      instr(BR, 3'd5, 0, 0, 32'h8000_0000, 32'd1);
      instr(BR, 3'd6, 0, 0, 32'd1, 32'hFFFF_FFFF);
      instr(BR, 3'd7, 0, 0, 32'd1, 32'd2);
      pin(18'h00840);
      instr(SW, 3'd2, 0, 2);
      // reset lands while MEMWRITE is completing
      c_op = SW; c_f3 = 3'd2;
      push(1'b0, 1'b1, ov(1,0,0,1,1,0,0,2,0,2,0,0), '1, "fetch");
      push(1'b0, 1'b0, ov(0,0,0,0,0,0,1,1,0,0,1,0), '1, "decode");
      push(1'b0, 1'b0, ov(0,0,0,0,0,0,2,1,0,0,1,0), '1, "memadr");
      push(1'b1, 1'b1, 18'h0, RMASK, "memwrite_rst");
      instr(RT, 3'd0, 0, 0);
      instr(BR, 3'd2, 0, 0, 32'd3, 32'd4);
      m_trap(3);
      pin(18'h00001);
      m_reset();
      instr(RT, 3'd0, 0, 0);

      m_sel = 1'b1; mt = 4; fb = 1'b0;
      m_reset(); m_reset();
      instr(BR, 3'd6, 0, 0, 32'd1, 32'd2);
      m_trap(2);
      m_reset();
      instr(BR, 3'd0, 0, 0, 32'd5, 32'd5);
      n0 = q.size(); instr(RT, 3'd0, 10, 0); chk_int("timeout_fetch_cycles", q.size() - n0, 5);
      m_trap(3);
      m_reset();
      instr(7'b0000000, 3'd0, 0, 0);
      m_trap(4);
      m_reset();
      instr(LW, 3'd2, 0, 4);
      instr(LW, 3'd2, 0, 9);
      m_trap(2);
      m_reset();
      instr(AU, 3'd0, 4, 0);

      while (q.size() != 0) begin
         @(posedge clk); #1;
         cur = q.pop_front();
         op = cur.op; funct3 = cur.f3; {Zero, Neg, Ovf, Carry} = cur.fl;
         mem_ready = cur.rdy;
         rst1 = cur.sel ? 1'b1 : cur.rst;
         rst2 = cur.sel ? cur.rst : 1'b1;
         chk_en = 1'b1;
      end
      @(negedge clk); #1;
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Parametrised multi-cycle successor to the single-cycle main decoder for the t1c RISC-V core. A Moore-style FSM sequences fetch, decode, execute, memory and write-back over several cycles against a shared instruction/data memory with a ready handshake. It resolves all six RV32I branch conditions and supports lui/auipc, jal and jalr. It flags illegal opcodes and memory timeouts through a sticky trap state. ALUOp feeds the existing ALU decoder, and select lines drive the multi-cycle datapath muxes.

## Interface
- MEM_TIMEOUT, default 15: maximum wait cycles on mem_ready before trapping; 0 disables the timeout.
- FULL_BRANCH, default 1: 1 decodes blt/bge/bltu/bgeu; 0 decodes beq/bne only, and other branch funct3 values trap.
- clk  in  1  system clock; the block uses this one clock only.
- reset  in  1  synchronous, active-high.
- op  in  7  instruction opcode, taken from the instruction register.
- funct3  in  3  instruction funct3.
- Zero, Neg, Ovf, Carry  in  1 each  ALU flags from the current combinational ALU result. Carry=1 means no borrow on subtraction.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- MemWrite  out  1  store strobe, valid only while mem_req=1.
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut.
- IRWrite, PCWrite, RegWrite  out  1 each  register write enables.
- ALUSrcA  out  2  ALU operand A: 00=PC, 01=OldPC, 10=rs1, 11=zero.
- ALUSrcB  out  2  ALU operand B: 00=rs2, 01=imm, 10=constant 4.
- ALUOp  out  2  00=add, 01=subtract/compare, 10=decode by funct.
- ResultSrc  out  2  result mux: 00=ALUOut, 01=read data, 10=ALU result.
- ImmSrc  out  3  immediate format: 000=I, 001=S, 010=B, 011=J, 100=U.
- fault  out  1  high while in TRAP.

## Operation
- States and transitions:
  - FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=PCWrite=mem_ready. Stays in FETCH until mem_ready, then goes to DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00, ImmSrc chosen from op, which precomputes the branch/jal target into ALUOut. Next state by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 or 0010111 → UPPER
    - any other op → TRAP
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ImmSrc I for lw or S for sw. Next state MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: mem_req=1, AdrSrc=1. Waits for mem_ready, then goes to MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
  - MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1. Waits for mem_ready, then goes to FETCH.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, then ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=taken, then FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1. ALUOut receives OldPC+4, then ALUWB.
  - JALR: ALUSrcA=10, ALUSrcB=01, ImmSrc I, then JAL.
  - UPPER: ALUSrcA=11 for lui or 01 for auipc, ALUSrcB=01, ImmSrc U, then ALUWB.
  - TRAP: absorbing. All enables and mem_req are 0, fault=1. Only reset exits.
- Branch condition for taken:
  - 000 beq: Zero
  - 001 bne: !Zero
  - 100 blt: Neg^Ovf
  - 101 bge: !(Neg^Ovf)
  - 110 bltu: !Carry
  - 111 bgeu: Carry
  - 010 and 011 → TRAP instead of FETCH, with no PCWrite.
- Every output not listed for a state is 0. ImmSrc is 000 when unused.
- Wait counter, width clog2(MEM_TIMEOUT+1):
  - Increments each cycle mem_req=1 and mem_ready=0.
  - Clears on mem_ready or on any state change.
  - When the counter equals MEM_TIMEOUT and mem_ready=0, the next state is TRAP and no write enable pulses.

## Timing
- Reset: state goes to FETCH, the counter and fault clear. While reset=1, mem_req and all write enables are forced to 0.
- State register updates on the rising edge of clk. Outputs decode from state only, except these combinational terms:
  - IRWrite, PCWrite in FETCH (depend on mem_ready).
  - PCWrite in BRANCH (depends on taken).
  - The timeout transition.
- Cycles per instruction with zero-wait memory (mem_ready=1 in the first request cycle):
  - R/I-type, sw, jal, lui, auipc: 4
  - lw, jalr: 5
  - branch: 3
- Each memory wait cycle adds 1 cycle.
- mem_ready sampled while mem_req=0 is ignored.
- Reset asserted mid-instruction aborts it on the next edge. No partial writes follow the reset edge.

## Structure
- riscv_ctrl_pkg holds:
  - opcode constants
  - state encoding localparams
  - branch funct3 codes
  - ALUSrcA/B, ResultSrc and ImmSrc encodings
- Sub-module branch_unit: combinational; inputs funct3 and the four flags plus FULL_BRANCH; outputs taken and illegal.
- alu_decoder remains separate and consumes ALUOp.

## Test plan
- add with mem_ready tied 1: states FETCH, DECODE, EXECR, ALUWB; RegWrite pulses exactly once in cycle 4; PCWrite only in cycle 1.
- lw with mem_ready low 3 cycles in MEMREAD: total 8 cycles; mem_req held; MEMWB RegWrite=1 with ResultSrc=01.
- blt with Neg=1, Ovf=0: PCWrite=1 in BRANCH. bgeu with Carry=0: PCWrite=0. funct3=010 → fault=1 on the next cycle.
- FULL_BRANCH=0 with bltu → TRAP. Opcode 0000000 → TRAP; fault stays 1 until reset, and reset returns the FSM to FETCH with fault=0.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH: TRAP entered on the 5th cycle; IRWrite never asserted.
- Reset pulsed during MEMWRITE with mem_ready=1: MemWrite=0 in the reset cycle; next state FETCH.
